perf_rx_tap: RTL
================

PERF_RX_TAP -- requirements
Module: perf_rx_tap

Interface
REQ-001 Parameter TS_WIDTH, default `PANIC_DESC_TS_SIZE, width of timestamps.
REQ-002 Parameter CLASS_NUM, default 5, number of valid flow classes (0..CLASS_NUM-1).
REQ-003 Clocking/reset SHALL be: one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  sole clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 s_axis_tvalid  input  1  monitored RX stream valid.
REQ-007 s_axis_tready  input  1  monitored RX stream ready (passive tap, never driven).
REQ-008 s_axis_tlast  input  1  monitored RX stream last beat.
REQ-009 s_axis_ts  input  TS_WIDTH  ingress timestamp, meaningful on first beat.
REQ-010 s_axis_class  input  8  flow class, meaningful on first beat.
REQ-011 enable  input  1  tap enable, sampled at first beat.
REQ-012 sample_div  input  8  emit one of every sample_div+1 eligible packets.
REQ-013 timestamp  output  TS_WIDTH  free-running time base.
REQ-014 m_perf_valid  output  1  one-cycle pulse per reported packet.
REQ-015 m_perf_ts  output  TS_WIDTH  captured ingress timestamp.
REQ-016 m_perf_class  output  5  captured flow class.
REQ-017 pkt_count  output  32  eligible packets seen.
REQ-018 err_count  output  16  packets with class >= CLASS_NUM.

Function
REQ-019 Beat handshake SHALL be s_axis_tvalid & s_axis_tready; non-handshake cycles SHALL be ignored.
REQ-020 FSM SHALL have states IDLE (awaiting first beat) and IN_PKT.
REQ-021 IDLE + handshake: capture ts, class, enable; tlast=1 -> stay IDLE and complete packet; tlast=0 -> IN_PKT.
REQ-022 IN_PKT + handshake with tlast=1 -> complete packet, go IDLE; otherwise stay.
REQ-023 Eligible packet: captured enable=1 and class < CLASS_NUM.
REQ-024 On eligible completion pkt_count SHALL increment by 1 (wraps at 2^32).
REQ-025 Sampler: counter loaded with sample_div; on eligible completion, counter==0 -> emit and reload sample_div, else decrement.
REQ-026 Emission: m_perf_valid=1 exactly one cycle after the completing handshake, m_perf_ts/m_perf_class held from capture, valid low otherwise.
REQ-027 Back-to-back completions (single-beat packets every cycle) SHALL each produce their own pulse, no loss.
REQ-028 timestamp SHALL increment by 1 every cycle, wrapping modulo 2^TS_WIDTH; consumers compute latency modulo that width.
REQ-029 enable=0 at first beat: framing still tracked, no count, no emission, no sampler change.
REQ-030 Output data fields SHALL hold last emitted values while m_perf_valid=0.

Reset
REQ-031 rst_n=0 at a clock edge: FSM->IDLE, timestamp, pkt_count, err_count, sampler counter, m_perf_valid, m_perf_ts, m_perf_class all 0.
REQ-032 Reset mid-packet: partial packet discarded; first handshake after reset release treated as first beat.
REQ-033 A pending emission coinciding with reset SHALL be suppressed.

Configuration
REQ-034 Macro PERF_RX_TAP_ERR_CNT_EN defined: class >= CLASS_NUM with enable=1 increments err_count on completion, saturating at 0xFFFF.
REQ-035 Macro absent: err_count tied 0; out-of-range packets silently ignored; all else identical.

Structure
REQ-036 `PANIC_DESC_TS_SIZE and PERF_CLASS_NUM constant SHALL live in shared panic_define.v.
REQ-037 Time base SHALL be sub-module perf_ts_counter (clk, rst_n, timestamp), reusable by downstream latency stages.

Verification
REQ-038 Reset, 10 idle cycles -> timestamp=10 at cycle 10 after release, all other outputs 0.
REQ-039 3-beat packet, ts=0x100, class=2, sample_div=0 -> single pulse one cycle after beat 3, m_perf_ts=0x100, m_perf_class=2, pkt_count=1.
REQ-040 8 single-beat packets consecutive cycles, sample_div=3 -> pulses for packets 1 and 5 only, pkt_count=8.
REQ-041 tready low on beat 2 for 4 cycles -> beat not counted, pulse still one cycle after real last handshake.
REQ-042 class=7, enable=1, macro defined -> no pulse, err_count=1, pkt_count unchanged; macro absent -> err_count=0.
REQ-043 rst_n low mid-packet after beat 1 of 3 -> after release, next beat with tlast=1 treated as single-beat packet, one pulse.

Source files
------------

// File: rtl/perf_rx_tap_pkg.sv
// perf_rx_tap_pkg -- shared definitions for the RX performance tap.
//   `PANIC_DESC_TS_SIZE : default timestamp width, also used by downstream
//                         latency stages that share the time base.
//   PERF_CLASS_NUM      : default number of valid flow classes.
//   state_e             : packet framing states.
//   class_ok()          : flow-class range check.
`ifndef PANIC_DESC_TS_SIZE
`define PANIC_DESC_TS_SIZE 32
`endif

package perf_rx_tap_pkg;

   localparam int PERF_CLASS_NUM = 5;

   typedef enum logic {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } state_e;

   function automatic logic class_ok(input logic [7:0] cls, input int num);
      return (int'({24'd0, cls}) < num);
   endfunction

endpackage

// File: rtl/perf_ts_counter.sv
// perf_ts_counter -- free-running time base, shared with latency stages.
//   clk       : sole clock
//   rst_n     : synchronous active-low reset, clears the count
//   timestamp : increments every cycle, wraps modulo 2^TS_WIDTH
module perf_ts_counter #(
   parameter int TS_WIDTH = `PANIC_DESC_TS_SIZE
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [TS_WIDTH-1:0] timestamp
);

   logic [TS_WIDTH-1:0] ts_q;

   always_ff @(posedge clk) begin
      if (!rst_n) ts_q <= '0;
      else        ts_q <= ts_q + TS_WIDTH'(1);
   end

   assign timestamp = ts_q;

endmodule

// File: rtl/perf_rx_tap.sv
// perf_rx_tap -- passive tap on an RX stream reporting sampled packet
// ingress timestamps and flow classes.
//   clk, rst_n            : clock, synchronous active-low reset
//   s_axis_tvalid/tready  : monitored handshake (never driven)
//   s_axis_tlast          : last beat of packet
//   s_axis_ts/class       : ingress timestamp and flow class, first beat
//   enable                : tap enable, sampled at first beat
//   sample_div            : report one of every sample_div+1 eligible packets
//   timestamp             : free-running time base
//   m_perf_valid/ts/class : one-cycle report pulse, data held between pulses
//   pkt_count             : eligible packets completed
//   err_count             : out-of-range class packets (only with macro)
// Build option: PERF_RX_TAP_ERR_CNT_EN enables the saturating err_count;
// without it err_count reads 0.
//
// state  | meaning
// IDLE   | waiting for the first beat of a packet
// IN_PKT | first beat taken, waiting for the tlast handshake
module perf_rx_tap
   import perf_rx_tap_pkg::*;
#(
   parameter int TS_WIDTH  = `PANIC_DESC_TS_SIZE,
   parameter int CLASS_NUM = PERF_CLASS_NUM
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                s_axis_tvalid,
   input  logic                s_axis_tready,
   input  logic                s_axis_tlast,
   input  logic [TS_WIDTH-1:0] s_axis_ts,
   input  logic [7:0]          s_axis_class,
   input  logic                enable,
   input  logic [7:0]          sample_div,
   output logic [TS_WIDTH-1:0] timestamp,
   output logic                m_perf_valid,
   output logic [TS_WIDTH-1:0] m_perf_ts,
   output logic [4:0]          m_perf_class,
   output logic [31:0]         pkt_count,
   output logic [15:0]         err_count
);

   state_e              state_q, state_d;
   logic                hs;
   logic [TS_WIDTH-1:0] cap_ts_q;
   logic [7:0]          cap_class_q;
   logic                cap_en_q;
   logic [7:0]          smp_cnt_q;
   logic                valid_q;
   logic [TS_WIDTH-1:0] perf_ts_q;
   logic [4:0]          perf_class_q;
   logic [31:0]         pkt_count_q;

   logic [TS_WIDTH-1:0] pkt_ts;
   logic [7:0]          pkt_class;
   logic                pkt_en;
   logic                done;
   logic                elig;
   logic                emit;

   assign hs = s_axis_tvalid & s_axis_tready;

   perf_ts_counter #(.TS_WIDTH(TS_WIDTH)) u_ts (
      .clk       (clk),
      .rst_n     (rst_n),
      .timestamp (timestamp)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (hs && !s_axis_tlast) state_d = IN_PKT;
         IN_PKT:  if (hs &&  s_axis_tlast) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A single-beat packet completes in IDLE before anything is captured,
   // so its attributes come straight from the bus.
   always_comb begin
      pkt_ts    = cap_ts_q;
      pkt_class = cap_class_q;
      pkt_en    = cap_en_q;
      case (state_q)
         IDLE: begin
            pkt_ts    = s_axis_ts;
            pkt_class = s_axis_class;
            pkt_en    = enable;
         end
         default: ;
      endcase
   end

   assign done = hs & s_axis_tlast;
   assign elig = done & pkt_en & class_ok(pkt_class, CLASS_NUM);
   assign emit = elig & (smp_cnt_q == 8'd0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cap_ts_q     <= '0;
         cap_class_q  <= '0;
         cap_en_q     <= 1'b0;
         smp_cnt_q    <= '0;
         valid_q      <= 1'b0;
         perf_ts_q    <= '0;
         perf_class_q <= '0;
         pkt_count_q  <= '0;
      end else begin
         if (state_q == IDLE && hs) begin
            cap_ts_q    <= s_axis_ts;
            cap_class_q <= s_axis_class;
            cap_en_q    <= enable;
         end
         if (elig) begin
            pkt_count_q <= pkt_count_q + 32'd1;
            smp_cnt_q   <= (smp_cnt_q == 8'd0) ? sample_div : smp_cnt_q - 8'd1;
         end
         valid_q <= emit;
         if (emit) begin
            perf_ts_q    <= pkt_ts;
            perf_class_q <= pkt_class[4:0];
         end
      end
   end

`ifdef PERF_RX_TAP_ERR_CNT_EN
   logic [15:0] err_count_q;
   logic        err_hit;

   assign err_hit = done & pkt_en & ~class_ok(pkt_class, CLASS_NUM);

   always_ff @(posedge clk) begin
      if (!rst_n)                                err_count_q <= '0;
      else if (err_hit && err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
   end

   assign err_count = err_count_q;
`else
   assign err_count = '0;
`endif

   assign m_perf_valid = valid_q;
   assign m_perf_ts    = perf_ts_q;
   assign m_perf_class = perf_class_q;
   assign pkt_count    = pkt_count_q;

endmodule
